// File: rtl/step4_normalize.sv
// Normalize/round stage of the FP MAC multiply path: S1 normalizes the raw significand
// product into [1,2), S2 rounds to nearest-even, adjusts the exponent and flags ovf/zero.
module step4_normalize #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 10,
    localparam int PW    = 2 * MAN_W + 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_out_sign,
    input  logic [EXP_W-1:0] in_ex_add_out,
    input  logic [PW-1:0]    in_sig_mul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_mant,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic             s1Valid_q;
    logic             s1Sign_q,  s1Sign_d;
    logic [MAN_W-1:0] s1Frac_q,  s1Frac_d;
    logic             s1Rinc_q,  s1Rinc_d;
    logic [EXP_W:0]   s1Exp_q,   s1Exp_d;
    logic             s1Zero_q,  s1Zero_d;

    logic             outValid_q;
    logic             outSign_q, outSign_d;
    logic [EXP_W-1:0] outExp_q,  outExp_d;
    logic [MAN_W-1:0] outMant_q, outMant_d;
    logic             outOvf_q,  outOvf_d;
    logic             outZero_q, outZero_d;

    logic             guardBit, stickyBit;
    logic [MAN_W:0]   mantRound;
    logic [MAN_W-1:0] mantAdj;
    logic [EXP_W:0]   expAdj;
    logic             s2Adv, s1Adv;

    assign s2Adv    = !outValid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;

    // A product >= 2.0 shifts right by one, bumping the exponent.
    always_comb begin
        s1Frac_d  = in_sig_mul_out[PW-3 -: MAN_W];
        guardBit  = in_sig_mul_out[PW-3-MAN_W];
        stickyBit = |in_sig_mul_out[PW-4-MAN_W:0];
        s1Exp_d   = {1'b0, in_ex_add_out};
        if (in_sig_mul_out[PW-1]) begin
            s1Frac_d  = in_sig_mul_out[PW-2 -: MAN_W];
            guardBit  = in_sig_mul_out[PW-2-MAN_W];
            stickyBit = |in_sig_mul_out[PW-3-MAN_W:0];
            s1Exp_d   = {1'b0, in_ex_add_out} + {{EXP_W{1'b0}}, 1'b1};
        end
        s1Rinc_d = guardBit && (stickyBit || s1Frac_d[0]);
        s1Zero_d = (in_sig_mul_out == '0);
        s1Sign_d = in_out_sign;
    end

    always_comb begin
        mantRound = {1'b0, s1Frac_q} + {{MAN_W{1'b0}}, s1Rinc_q};
        mantAdj   = mantRound[MAN_W-1:0];
        expAdj    = s1Exp_q;
        if (mantRound[MAN_W]) begin
            mantAdj = '0;
            expAdj  = s1Exp_q + {{EXP_W{1'b0}}, 1'b1};
        end
        outSign_d = s1Sign_q;
        outExp_d  = '0;
        outMant_d = '0;
        outOvf_d  = 1'b0;
        outZero_d = 1'b0;
        // True zero wins over everything; underflow to exponent 0 is flushed.
        if (s1Zero_q) begin
            outZero_d = 1'b1;
        end else if (expAdj >= EXP_MAX) begin
            outExp_d = '1;
            outOvf_d = 1'b1;
        end else if (expAdj == '0) begin
            outZero_d = 1'b1;
        end else begin
            outExp_d  = expAdj[EXP_W-1:0];
            outMant_d = mantAdj;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1Valid_q <= 1'b0;
            s1Sign_q  <= 1'b0;
            s1Frac_q  <= '0;
            s1Rinc_q  <= 1'b0;
            s1Exp_q   <= '0;
            s1Zero_q  <= 1'b0;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Sign_q <= s1Sign_d;
                s1Frac_q <= s1Frac_d;
                s1Rinc_q <= s1Rinc_d;
                s1Exp_q  <= s1Exp_d;
                s1Zero_q <= s1Zero_d;
            end
        end
    end

    // Output fields only load on a real transfer so they hold steady while stalled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            outValid_q <= 1'b0;
            outSign_q  <= 1'b0;
            outExp_q   <= '0;
            outMant_q  <= '0;
            outOvf_q   <= 1'b0;
            outZero_q  <= 1'b0;
        end else if (s2Adv) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outSign_q <= outSign_d;
                outExp_q  <= outExp_d;
                outMant_q <= outMant_d;
                outOvf_q  <= outOvf_d;
                outZero_q <= outZero_d;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_sign  = outSign_q;
    assign out_exp   = outExp_q;
    assign out_mant  = outMant_q;
    assign out_ovf   = outOvf_q;
    assign out_zero  = outZero_q;

endmodule

// File: tb/tb_step4_normalize.sv
// Directed bench for step4_normalize: rounding/exponent corner vectors, backpressure
// ordering with a stalled output, and an asynchronous reset in the middle of a stream.
module tb_step4_normalize;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_out_sign = 1'b0;
    logic [7:0]  in_ex_add_out = '0;
    logic [21:0] in_sig_mul_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [9:0]  out_mant;
    logic        out_ovf;
    logic        out_zero;

    int errorCount = 0;
    int checkCount = 0;

    logic [21:0] vecP[5];
    logic [7:0]  vecE[5];
    logic        vecS[5];
    logic [20:0] vecExp[5];

    always #5 clock = ~clock;

    step4_normalize dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_out_sign   (in_out_sign),
        .in_ex_add_out (in_ex_add_out),
        .in_sig_mul_out(in_sig_mul_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sign      (out_sign),
        .out_exp       (out_exp),
        .out_mant      (out_mant),
        .out_ovf       (out_ovf),
        .out_zero      (out_zero)
    );

    function automatic logic [20:0] pk(input logic s, input logic [7:0] e, input logic [9:0] m,
                                       input logic o, input logic z);
        return {s, e, m, o, z};
    endfunction

    function automatic logic [20:0] outBus();
        return {out_sign, out_exp, out_mant, out_ovf, out_zero};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated transfer: result must appear exactly two cycles after acceptance.
    task automatic applyStimulus(input string tag, input logic [21:0] p, input logic [7:0] e,
                                 input logic s, input logic [20:0] expected);
        @(negedge clock);
        in_valid = 1'b1;
        in_sig_mul_out = p;
        in_ex_add_out = e;
        in_out_sign = s;
        #1;
        checkOutput({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(outBus()), 32'(expected));
    endtask

    task automatic runBackpressure();
        int sent = 0;
        int got = 0;
        logic [20:0] expQ[$];
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clock);
            out_ready = (c >= 4);
            if (sent < 5) begin
                in_valid = 1'b1;
                in_sig_mul_out = vecP[sent];
                in_ex_add_out = vecE[sent];
                in_out_sign = vecS[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2 || c == 3) begin
                checkOutput("bpAccepted", 32'(sent), 32'd2);
                checkOutput("bpReadyLow", 32'(in_ready), 32'd0);
                checkOutput("bpHoldValid", 32'(out_valid), 32'd1);
                checkOutput("bpHoldData", 32'(outBus()), 32'(vecExp[0]));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("bpExtra", 32'd1, 32'd0);
                end else begin
                    checkOutput("bpOrder", 32'(outBus()), 32'(expQ.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(vecExp[sent]);
                sent++;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("bpCount", 32'(got), 32'd5);
    endtask

    task automatic runMidReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_sig_mul_out = vecP[i];
            in_ex_add_out = vecE[i];
            in_out_sign = vecS[i];
        end
        #2;
        checkOutput("rstPreValid", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstData", 32'(outBus()), 32'd0);
        checkOutput("rstReady", 32'(in_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("rstNoResidue", 32'(out_valid), 32'd0);
        end
        checkOutput("rstReadyAfter", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecP[0] = 22'h100000; vecE[0] = 8'd127; vecS[0] = 1'b0; vecExp[0] = pk(1'b0, 8'd127, 10'h000, 1'b0, 1'b0);
        vecP[1] = 22'h300000; vecE[1] = 8'd127; vecS[1] = 1'b1; vecExp[1] = pk(1'b1, 8'd128, 10'h200, 1'b0, 1'b0);
        vecP[2] = 22'h100600; vecE[2] = 8'd50;  vecS[2] = 1'b0; vecExp[2] = pk(1'b0, 8'd50,  10'h002, 1'b0, 1'b0);
        vecP[3] = 22'h1FFE00; vecE[3] = 8'd254; vecS[3] = 1'b1; vecExp[3] = pk(1'b1, 8'hFF, 10'h000, 1'b1, 1'b0);
        vecP[4] = 22'h000000; vecE[4] = 8'd90;  vecS[4] = 1'b1; vecExp[4] = pk(1'b1, 8'h00, 10'h000, 1'b0, 1'b1);

        #12;
        checkOutput("resetValid", 32'(out_valid), 32'd0);
        checkOutput("resetData", 32'(outBus()), 32'd0);
        checkOutput("resetReady", 32'(in_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;

        applyStimulus("one",      22'h100000, 8'd127, 1'b0, pk(1'b0, 8'd127, 10'h000, 1'b0, 1'b0));
        applyStimulus("three",    22'h300000, 8'd127, 1'b1, pk(1'b1, 8'd128, 10'h200, 1'b0, 1'b0));
        applyStimulus("tieUp",    22'h100600, 8'd127, 1'b0, pk(1'b0, 8'd127, 10'h002, 1'b0, 1'b0));
        applyStimulus("tieDown",  22'h100200, 8'd127, 1'b0, pk(1'b0, 8'd127, 10'h000, 1'b0, 1'b0));
        applyStimulus("sticky",   22'h100201, 8'd127, 1'b0, pk(1'b0, 8'd127, 10'h001, 1'b0, 1'b0));
        applyStimulus("carry",    22'h1FFE00, 8'd100, 1'b0, pk(1'b0, 8'd101, 10'h000, 1'b0, 1'b0));
        applyStimulus("carryOvf", 22'h1FFE00, 8'd254, 1'b0, pk(1'b0, 8'hFF, 10'h000, 1'b1, 1'b0));
        applyStimulus("trueZero", 22'h000000, 8'd90,  1'b1, pk(1'b1, 8'h00, 10'h000, 1'b0, 1'b1));
        applyStimulus("flush",    22'h100000, 8'd0,   1'b0, pk(1'b0, 8'h00, 10'h000, 1'b0, 1'b1));
        applyStimulus("exp0Norm", 22'h300000, 8'd0,   1'b0, pk(1'b0, 8'd1,  10'h200, 1'b0, 1'b0));
        applyStimulus("exp255",   22'h100000, 8'd255, 1'b1, pk(1'b1, 8'hFF, 10'h000, 1'b1, 1'b0));
        applyStimulus("exp255Hi", 22'h300000, 8'd255, 1'b0, pk(1'b0, 8'hFF, 10'h000, 1'b1, 1'b0));
        applyStimulus("hiRound",  22'h3FFC00, 8'd20,  1'b0, pk(1'b0, 8'd22,  10'h000, 1'b0, 1'b0));

        runBackpressure();
        runMidReset();
        applyStimulus("recover",  22'h300000, 8'd127, 1'b1, pk(1'b1, 8'd128, 10'h200, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
